// File: rtl/lab_pkg.sv
// Shared constants, FSM states and reset coefficients for the colour-space
// matrix sequencer.
package lab_pkg;
    localparam int DW    = 16;
    localparam int FRAC  = 13;
    localparam int NCOEF = 9;

    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} st_e;

    localparam logic [DW-1:0] C_RST0 = 16'h127A;
    localparam logic [DW-1:0] C_RST1 = 16'h127A;
    localparam logic [DW-1:0] C_RST2 = 16'h127A;
    localparam logic [DW-1:0] C_RST3 = 16'h0D10;
    localparam logic [DW-1:0] C_RST4 = 16'h0D10;
    localparam logic [DW-1:0] C_RST5 = 16'hE5DF;
    localparam logic [DW-1:0] C_RST6 = 16'h16A1;
    localparam logic [DW-1:0] C_RST7 = 16'hE95F;
    localparam logic [DW-1:0] C_RST8 = 16'h0000;

    function automatic logic [DW-1:0] coef_rst(input int idx);
        case (idx)
            0:       return C_RST0;
            1:       return C_RST1;
            2:       return C_RST2;
            3:       return C_RST3;
            4:       return C_RST4;
            5:       return C_RST5;
            6:       return C_RST6;
            7:       return C_RST7;
            default: return C_RST8;
        endcase
    endfunction
endpackage

// File: rtl/lab_matrix_seq_if.sv
// Upstream/downstream handshake and coefficient bus of the matrix sequencer.
interface lab_matrix_seq_if #(
    parameter int DW = 16
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] x0, x1, x2;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] y0, y1, y2;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          cfg_err;
    logic          busy;

    modport master (
        output valid, x0, x1, x2, res_ready, cfg_we, cfg_addr, cfg_data,
        input  ready, res_valid, y0, y1, y2, cfg_err, busy
    );
    modport slave (
        input  valid, x0, x1, x2, res_ready, cfg_we, cfg_addr, cfg_data,
        output ready, res_valid, y0, y1, y2, cfg_err, busy
    );
endinterface

// File: rtl/lab_mac.sv
// Shared signed multiplier feeding three row accumulators (32-bit wrap).
module lab_mac #(
    parameter int DW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic [1:0]             i_row,
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic [2:0][2*DW-1:0]   o_acc,
    output logic [2*DW-1:0]        o_acc_nxt
);
    logic signed [2*DW-1:0] w_prod;
    logic [2*DW-1:0]        w_sel;
    logic [2:0][2*DW-1:0]   r_acc;

    assign w_prod = i_a * i_b;

    always_comb begin
        w_sel = r_acc[0];
        case (i_row)
            2'd1:    w_sel = r_acc[1];
            2'd2:    w_sel = r_acc[2];
            default: w_sel = r_acc[0];
        endcase
    end

    assign o_acc_nxt = w_sel + w_prod;
    assign o_acc     = r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            case (i_row)
                2'd0:    r_acc[0] <= o_acc_nxt;
                2'd1:    r_acc[1] <= o_acc_nxt;
                2'd2:    r_acc[2] <= o_acc_nxt;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/lab_matrix_seq.sv
// 3x3 coefficient matrix times vector, one product per cycle, with a
// programmable coefficient bank that may only be written while idle.
module lab_matrix_seq #(
    parameter int DW   = lab_pkg::DW,
    parameter int FRAC = lab_pkg::FRAC
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic signed [DW-1:0] i_x0,
    input  logic signed [DW-1:0] i_x1,
    input  logic signed [DW-1:0] i_x2,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DW-1:0]        o_y0,
    output logic [DW-1:0]        o_y1,
    output logic [DW-1:0]        o_y2,
    input  logic                 i_cfg_we,
    input  logic [3:0]           i_cfg_addr,
    input  logic [DW-1:0]        i_cfg_data,
    output logic                 o_cfg_err,
    output logic                 o_busy
);
    import lab_pkg::*;

    localparam int AW = 2 * DW;

    st_e                  r_state, w_state_nxt;
    logic [3:0]           r_k;
    logic signed [DW-1:0] r_x [3];
    logic signed [DW-1:0] r_coef [9];
    logic [DW-1:0]        r_y0, r_y1, r_y2;
    logic                 r_cfg_err;
    logic                 w_accept, w_last, w_cfg_ok;
    logic [1:0]           w_row;
    logic signed [DW-1:0] w_xsel, w_coef;
    logic [2:0][AW-1:0]   w_acc;
    logic [AW-1:0]        w_acc_nxt;

    assign w_accept = (r_state == ST_IDLE) && i_valid;
    assign w_last   = (r_state == ST_MAC) && (r_k == 4'd8);
    assign w_cfg_ok = i_cfg_we && (r_state == ST_IDLE) && (i_cfg_addr <= 4'd8);
    assign w_coef   = r_coef[r_k];

    // k walks the matrix row-major: row = k/3, column = k%3
    always_comb begin
        w_row  = 2'd0;
        w_xsel = r_x[0];
        case (r_k)
            4'd1, 4'd4, 4'd7: w_xsel = r_x[1];
            4'd2, 4'd5, 4'd8: w_xsel = r_x[2];
            default:          w_xsel = r_x[0];
        endcase
        if (r_k >= 4'd6)      w_row = 2'd2;
        else if (r_k >= 4'd3) w_row = 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_valid) w_state_nxt = ST_MAC;
            ST_MAC:  if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: if (i_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k       <= '0;
            r_x       <= '{default: '0};
            r_y0      <= '0;
            r_y1      <= '0;
            r_y2      <= '0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NCOEF; i++) r_coef[i] <= DW'(coef_rst(i));
        end else begin
            r_cfg_err <= i_cfg_we && !w_cfg_ok;
            if (w_cfg_ok) r_coef[i_cfg_addr] <= i_cfg_data;
            if (w_accept) begin
                r_x[0] <= i_x0;
                r_x[1] <= i_x1;
                r_x[2] <= i_x2;
                r_k    <= '0;
            end else if ((r_state == ST_MAC) && !w_last) begin
                r_k <= r_k + 4'd1;
            end
            // row 2 is still being summed on the last edge, so take its next value
            if (w_last) begin
                r_y0 <= w_acc[0][DW+FRAC-1:FRAC];
                r_y1 <= w_acc[1][DW+FRAC-1:FRAC];
                r_y2 <= w_acc_nxt[DW+FRAC-1:FRAC];
            end
        end
    end

    lab_mac #(.DW(DW)) u_mac (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_accept),
        .i_en      (r_state == ST_MAC),
        .i_row     (w_row),
        .i_a       (w_coef),
        .i_b       (w_xsel),
        .o_acc     (w_acc),
        .o_acc_nxt (w_acc_nxt)
    );

    assign o_ready   = (r_state == ST_IDLE);
    assign o_valid   = (r_state == ST_DONE);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_y0      = r_y0;
    assign o_y1      = r_y1;
    assign o_y2      = r_y2;
    assign o_cfg_err = r_cfg_err;
endmodule

// File: doc/lab_matrix_seq.md
LAB_MATRIX_SEQ -- requirements
Module: lab_matrix_seq

Interface
REQ-001 Parameters SHALL be: DW, 16, data/coefficient width (signed Q3.13); FRAC, 13, fractional bits.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 i_clk  input  1  rising-edge clock.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_valid  input  1  input vector present.
REQ-006 o_ready  output  1  block can accept an input vector.
REQ-007 i_x0, i_x1, i_x2  input  16 each  signed Q3.13 input vector (logL, logM, logS).
REQ-008 o_valid  output  1  result vector present.
REQ-009 i_ready  input  1  downstream accepts the result.
REQ-010 o_y0, o_y1, o_y2  output  16 each  signed Q3.13 result (l, a, b).
REQ-011 i_cfg_we  input  1  coefficient write strobe.
REQ-012 i_cfg_addr  input  4  coefficient index 0..8, row-major (addr = 3*row + col).
REQ-013 i_cfg_data  input  16  signed Q3.13 coefficient.
REQ-014 o_cfg_err  output  1  one-cycle pulse on a rejected write.
REQ-015 o_busy  output  1  high in any state other than IDLE.

Function
REQ-016 The block SHALL compute y = C*x with one shared 16x16 signed multiplier, one product per cycle.
REQ-017 The FSM SHALL have exactly three states: IDLE, MAC and DONE.
REQ-018 IDLE: o_ready=1; on an edge with i_valid=1, the block SHALL latch i_x0..2, clear k=0 and go to MAC.
REQ-019 MAC: each edge SHALL accumulate C[k]*x[k%3] into the row-k/3 accumulator; after k=8 the FSM SHALL go to DONE. Total 9 MAC edges.
REQ-020 o_valid SHALL rise exactly 9 cycles after the acceptance edge.
REQ-021 o_ready SHALL be 0 in MAC and DONE; minimum throughput is one vector per 11 cycles.
REQ-022 DONE: o_valid=1 and o_y0..2 SHALL hold stable until an edge with i_ready=1, then the FSM SHALL return to IDLE with o_valid=0.
REQ-023 Arithmetic: each product SHALL be 32-bit signed; the accumulator SHALL be 32-bit signed, wrapping with no saturation; y = acc[28:13] (truncation).
REQ-024 Coefficient writes SHALL be accepted only in IDLE with i_cfg_addr<=8.
REQ-025 A write with i_cfg_addr>8, or a write in MAC or DONE, SHALL be discarded and SHALL pulse o_cfg_err for one cycle.
REQ-026 When a write and an input acceptance occur on the same IDLE edge, both SHALL take effect, and the computation SHALL use the new coefficient.
REQ-027 Inputs SHALL be sampled only at acceptance; later i_x changes SHALL have no effect on the result in progress.

Reset
REQ-028 On i_rst, the FSM SHALL enter IDLE; k, the accumulators, o_y0..2, o_valid, o_cfg_err and o_busy SHALL be 0; o_ready SHALL be 1 on the cycle after reset.
REQ-029 Reset SHALL reload coefficients 0..8 = 0x127A, 0x127A, 0x127A, 0x0D10, 0x0D10, 0xE5DF, 0x16A1, 0xE95F, 0x0000.
REQ-030 Reset during MAC or DONE SHALL abandon the vector in progress; no o_valid SHALL follow.

Structure
REQ-031 Shared package lab_pkg SHALL hold DW, FRAC, the state enumeration and the nine reset coefficient constants.
REQ-032 The multiply-accumulate datapath SHALL be one sub-module, lab_mac (signed 16x16 multiply, 32-bit accumulate, clear input).

Verification
REQ-033 Reset coefficients, x=(0x2000, 0x2000, 0x2000) -> o_valid 9 cycles after accept, y=(0x376E, 0xFFFF, 0x0000).
REQ-034 Write identity (0x2000 on the diagonal, 0 elsewhere), then x=(0x1000, 0xF000, 0x7FFF) -> y=(0x1000, 0xF000, 0x7FFF).
REQ-035 Hold i_ready=0 for 5 cycles in DONE -> o_valid and y stable throughout, o_ready=0; the output is consumed on the first i_ready=1 edge.
REQ-036 Coefficient write at addr 4 during MAC, and a write at addr 12 in IDLE -> o_cfg_err pulses once for each; the coefficients are unchanged and the current result is unaffected.
REQ-037 Assert i_rst at MAC k=5 -> next cycle IDLE with o_ready=1, no o_valid, and coefficients back to the reset values.
REQ-038 Simultaneous i_cfg_we (addr 0, 0x0000) and i_valid in IDLE with x=(0x2000, 0x2000, 0x2000) -> y0=0x24F4.
